// File: rtl/bus_pkg.sv
// Shared definitions for the external-bus sequencer.
//   PH_*     : phase codes presented on pin_phase (0 idle, 1 addr, 2 turn, 3 data)
//   state_t  : FSM state type; encodings equal the phase codes so the state
//              register can drive pin_phase directly
//   nbeat()  : number of address beats for a given address/pin width
package bus_pkg;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_ADDR = 2'd1;
  localparam logic [1:0] PH_TURN = 2'd2;
  localparam logic [1:0] PH_DATA = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = PH_IDLE,
    ST_ADDR = PH_ADDR,
    ST_TURN = PH_TURN,
    ST_DATA = PH_DATA
  } state_t;

  function automatic int nbeat(input int addr_w, input int pin_w);
    return addr_w / pin_w;
  endfunction

endpackage

// File: rtl/beat_shifter.sv
// Address beat shifter.
// Holds the transaction address and presents its low PIN_W bits as the
// current beat; each shift moves the next-higher beat into the low position.
//   clk   in  : clock
//   rst   in  : synchronous active-high reset, clears the register
//   load  in  : capture din (takes priority over clr/shift)
//   clr   in  : clear to zero (idle pin value)
//   shift in  : shift right by PIN_W, zero fill
//   din   in  : address to load
//   beat  out : low PIN_W bits of the register
module beat_shifter #(
  parameter int ADDR_W = 16,
  parameter int PIN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              shift,
  input  logic [ADDR_W-1:0] din,
  output logic [PIN_W-1:0]  beat
);

  logic [ADDR_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (clr) begin
      sr <= '0;
    end else if (shift) begin
      sr <= sr >> PIN_W;
    end
  end

  assign beat = sr[PIN_W-1:0];

endmodule

// File: rtl/mux_bus_controller.sv
// External-bus transaction sequencer between the CPU core and the pin groups.
// Accepts one request, serialises the address onto pin_out (low beat first),
// optionally idles TURN_CYC turnaround cycles, then runs one data phase on the
// bidirectional pins (drive on write, sample on read) until ext_rdy or a
// wait timeout, and reports completion with a one-cycle rsp_valid pulse.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/ready           : request handshake; req_rw 0=read 1=write
//   req_addr, req_wdata       : request address and write data
//   rsp_valid/rdata/err       : completion pulse, read data (held), timeout flag
//   ext_rdy                   : external device ready during data phase
//   pin_out                   : address beats, zero when idle
//   pin_phase                 : 0 idle, 1 addr, 2 turn, 3 data
//   uio_in/uio_out/uio_oe     : bidirectional pin group
module mux_bus_controller
  import bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int PIN_W    = 8,
  parameter int TURN_CYC = 1,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              ext_rdy,
  output logic [PIN_W-1:0]  pin_out,
  output logic [1:0]        pin_phase,
  input  logic [PIN_W-1:0]  uio_in,
  output logic [PIN_W-1:0]  uio_out,
  output logic [PIN_W-1:0]  uio_oe
);

  localparam int NBEAT  = nbeat(ADDR_W, PIN_W);
  localparam int BEAT_W = $clog2(NBEAT + 1);
  localparam int TURN_W = 2;
  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX : 1);

  state_t              state;
  state_t              state_nxt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [TURN_W-1:0]   turn_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                accept;
  logic                beat_last;
  logic                turn_last;
  logic                timeout;
  logic                done;

  assign accept    = req_valid && req_ready;
  assign beat_last = (beat_cnt == BEAT_W'(NBEAT - 1));
  assign turn_last = (turn_cnt == TURN_W'(TURN_CYC - 1));
  // ext_rdy is checked before timeout, so a ready on the last allowed cycle succeeds
  assign timeout   = (WAIT_MAX > 0) && (wait_cnt == WAIT_W'(WAIT_MAX - 1));
  assign done      = (state == ST_DATA) && (ext_rdy || timeout);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (beat_last) begin
          if (TURN_CYC > 0) state_nxt = ST_TURN;
          else              state_nxt = ST_DATA;
        end
      end
      ST_TURN: if (turn_last) state_nxt = ST_DATA;
      ST_DATA: if (ext_rdy || timeout) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      uio_out   <= '0;
      uio_oe    <= '0;
      beat_cnt  <= '0;
      turn_cnt  <= '0;
      wait_cnt  <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= done;
      rsp_err   <= done && !ext_rdy;
      if (done && ext_rdy && !rw_q) rsp_rdata <= uio_in;

      if (accept) begin
        rw_q    <= req_rw;
        wdata_q <= req_wdata;
      end

      // pin group is driven only while the data phase of a write is active
      if (state_nxt == ST_DATA && rw_q) begin
        uio_out <= wdata_q;
        uio_oe  <= '1;
      end else begin
        uio_out <= '0;
        uio_oe  <= '0;
      end

      // counters clear whenever the state changes and saturate otherwise
      if (state_nxt != state)                 beat_cnt <= '0;
      else if (state == ST_ADDR && !beat_last) beat_cnt <= beat_cnt + 1'b1;

      if (state_nxt != state)                 turn_cnt <= '0;
      else if (state == ST_TURN && !turn_last) turn_cnt <= turn_cnt + 1'b1;

      if (state_nxt != state)                 wait_cnt <= '0;
      else if (state == ST_DATA && !ext_rdy && wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // shifter register doubles as the registered pin_out; it stops shifting on
  // the last beat so that beat is held through turnaround and data
  beat_shifter #(
    .ADDR_W (ADDR_W),
    .PIN_W  (PIN_W)
  ) u_beat_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .clr   (done),
    .shift ((state == ST_ADDR) && !beat_last),
    .din   (req_addr),
    .beat  (pin_out)
  );

  assign pin_phase = state;

endmodule

// File: tb/tb_mux_bus_controller.sv
module tb_mux_bus_controller;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        ext_rdy;
  logic [7:0]  pin_out;
  logic [1:0]  pin_phase;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  logic        req_valid2;
  logic        req_ready2;
  logic [23:0] req_addr2;
  logic        rsp_valid2;
  logic [7:0]  rsp_rdata2;
  logic        rsp_err2;
  logic [7:0]  pin_out2;
  logic [1:0]  pin_phase2;
  logic [7:0]  uio_out2;
  logic [7:0]  uio_oe2;

  int n_pass;
  int n_total;

  mux_bus_controller dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ext_rdy   (ext_rdy),
    .pin_out   (pin_out),
    .pin_phase (pin_phase),
    .uio_in    (uio_in),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe)
  );

  mux_bus_controller #(
    .ADDR_W (24)
  ) dut_w24 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid2),
    .req_ready (req_ready2),
    .req_rw    (req_rw),
    .req_addr  (req_addr2),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid2),
    .rsp_rdata (rsp_rdata2),
    .rsp_err   (rsp_err2),
    .ext_rdy   (ext_rdy),
    .pin_out   (pin_out2),
    .pin_phase (pin_phase2),
    .uio_in    (uio_in),
    .uio_out   (uio_out2),
    .uio_oe    (uio_oe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          wait_n;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_txn(input vec_t v);
    int  k;
    int  d;
    bit  done;
    logic rdy;
    k    = 0;
    d    = 0;
    done = 0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("rsp_pulse_low", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1;
    req_rw    = v.rw;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    ext_rdy   = 1'b0;
    uio_in    = 8'h00;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = 16'hDEAD;
      req_wdata = 8'h00;
      case (pin_phase)
        2'd1: begin
          if (k == 0) chk("beat0", 32'(pin_out), 32'(v.b0));
          else        chk("beat1", 32'(pin_out), 32'(v.b1));
          chk("addr_oe", 32'(uio_oe), 32'd0);
          k++;
        end
        2'd2: begin
          chk("turn_hold", 32'(pin_out), 32'(v.b1));
          chk("turn_oe", 32'(uio_oe), 32'd0);
        end
        2'd3: begin
          d++;
          rdy     = (d > v.wait_n);
          ext_rdy = rdy;
          uio_in  = rdy ? v.din : ~v.din;
          chk("data_oe", 32'(uio_oe), v.rw ? 32'hFF : 32'h00);
          if (v.rw) chk("data_out", 32'(uio_out), 32'(v.wdata));
        end
        default: ;
      endcase
      if (rsp_valid) begin
        done    = 1;
        ext_rdy = 1'b0;
        chk("latency", c, v.lat);
        chk("rdata", 32'(rsp_rdata), 32'(v.rdata));
        chk("err", 32'(rsp_err), 32'(v.err));
      end
    end
    chk("rsp_arrived", 32'(done), 32'd1);
    chk("beat_count", k, 2);
  endtask

  initial begin
    int   n_acc;
    int   n_rsp;
    int   k;
    bit   found;
    bit   done;
    logic [7:0] exp24 [3];

    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    ext_rdy    = 1'b0;
    uio_in     = '0;
    req_valid2 = 1'b0;
    req_addr2  = '0;

    //        rw    addr      wdata  din    wait b0     b1     rdata  err  lat
    vecs[0] = '{1'b0, 16'hBEEF, 8'h00, 8'h5A, 0,  8'hEF, 8'hBE, 8'h5A, 1'b0, 5};
    vecs[1] = '{1'b1, 16'h1234, 8'hA5, 8'h00, 0,  8'h34, 8'h12, 8'h5A, 1'b0, 5};
    vecs[2] = '{1'b0, 16'hC3D2, 8'h00, 8'h7E, 3,  8'hD2, 8'hC3, 8'h7E, 1'b0, 8};
    vecs[3] = '{1'b0, 16'h0F00, 8'h00, 8'h11, 99, 8'h00, 8'h0F, 8'h7E, 1'b1, 19};
    vecs[4] = '{1'b1, 16'hFFFF, 8'h3C, 8'h00, 14, 8'hFF, 8'hFF, 8'h7E, 1'b0, 19};
    vecs[5] = '{1'b0, 16'h0001, 8'h00, 8'hFF, 0,  8'h01, 8'h00, 8'hFF, 1'b0, 5};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_pin_out",   32'(pin_out),   32'd0);
    chk("rst_pin_phase", 32'(pin_phase), 32'd0);
    chk("rst_uio_out",   32'(uio_out),   32'd0);
    chk("rst_uio_oe",    32'(uio_oe),    32'd0);

    for (int unsigned i = 0; i < 6; i++) run_txn(vecs[i]);

    // back-to-back: three reads, req_valid held high, ext_rdy tied high
    n_acc   = 0;
    n_rsp   = 0;
    req_rw  = 1'b0;
    ext_rdy = 1'b1;
    for (int c = 0; c < 30 && n_rsp < 3; c++) begin
      @(negedge clk);
      req_valid = (n_acc < 3);
      if (rsp_valid) begin
        n_rsp++;
        chk("b2b_rsp_cycle", c, 5 * n_rsp);
        chk("b2b_rdata", 32'(rsp_rdata), 32'h10 + 32'(n_rsp - 1));
      end
      if (req_valid && req_ready) begin
        chk("b2b_accept_cycle", c, 5 * n_acc);
        req_addr = 16'h0100 + 16'(n_acc);
        uio_in   = 8'h10 + 8'(n_acc);
        n_acc++;
      end
    end
    req_valid = 1'b0;
    ext_rdy   = 1'b0;
    chk("b2b_rsp_count", n_rsp, 3);

    // reset during the data phase of a write
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 16'h5555;
    req_wdata = 8'hC3;
    found     = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (pin_phase == 2'd3) found = 1;
    end
    chk("rst_reach_data", 32'(found), 32'd1);
    chk("rst_pre_oe", 32'(uio_oe), 32'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_oe",        32'(uio_oe),    32'd0);
    chk("rst_mid_uio_out",   32'(uio_out),   32'd0);
    chk("rst_mid_ready",     32'(req_ready), 32'd1);
    chk("rst_mid_phase",     32'(pin_phase), 32'd0);
    chk("rst_mid_pin_out",   32'(pin_out),   32'd0);
    chk("rst_mid_rdata",     32'(rsp_rdata), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // 24-bit address build: three beats, latency 3 + 1 + 1 + 1
    exp24[0] = 8'hEF;
    exp24[1] = 8'hCD;
    exp24[2] = 8'hAB;
    @(negedge clk);
    req_valid2 = 1'b1;
    req_rw     = 1'b0;
    req_addr2  = 24'hABCDEF;
    ext_rdy    = 1'b1;
    uio_in     = 8'h66;
    k          = 0;
    done       = 0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      req_valid2 = 1'b0;
      if (pin_phase2 == 2'd1) begin
        if (k < 3) chk("w24_beat", 32'(pin_out2), 32'(exp24[k]));
        k++;
      end
      if (rsp_valid2) begin
        done = 1;
        chk("w24_latency", c, 6);
        chk("w24_rdata", 32'(rsp_rdata2), 32'h66);
        chk("w24_err", 32'(rsp_err2), 32'd0);
      end
    end
    ext_rdy = 1'b0;
    chk("w24_rsp_arrived", 32'(done), 32'd1);
    chk("w24_beat_count", k, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
